reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
//
// PURPOSE
//   Output-side counterpart of the button conditioning path: turns clean, synchronous reset
//   requests (conditioned button, software register, watchdog) into stretched, ordered
//   active-low reset outputs. Peripherals are released first, then the core after a gap.
//   Also records the cause of the last reset. Sits in reset_ctrl, downstream of the
//   conditioned button.
//
// PARAMETERS
//   PULSE_LEN  32  cycles both resets stay asserted after the last request (>=1)
//   GAP_LEN    8   cycles between periph release and core release (>=1)
//
// PORTS
//   clk            in   1  system clock
//   rst_n          in   1  asynchronous active-low reset (power-on)
//   btn_req_i      in   1  conditioned button, level; held high extends the reset
//   sw_req_i       in   1  software reset request, 1-cycle pulse
//   wdog_req_i     in   1  watchdog reset request, 1-cycle pulse
//   periph_rst_n_o out  1  peripheral reset, active low, registered
//   core_rst_n_o   out  1  core reset, active low, registered
//   busy_o         out  1  high while a sequence is in progress (state != IDLE)
//   reason_o       out  2  last cause: 00 POR, 01 button, 10 software, 11 watchdog
//
// BEHAVIOUR
//   - req = btn_req_i | sw_req_i | wdog_req_i. All inputs are synchronous to clk.
//   - rst_n low (async): state=ASSERT, ctr=0, periph_rst_n_o=0, core_rst_n_o=0,
//     busy_o=1, reason_o=00. Full sequence runs after rst_n rises. Same holds if rst_n
//     drops mid-sequence.
//   - States:
//     ASSERT: both outputs low. ctr increments each cycle while req=0. req=1 forces ctr=0.
//             When ctr==PULSE_LEN-1 and req=0: go to GAP, ctr=0.
//     GAP:    periph_rst_n_o=1, core_rst_n_o=0. ctr increments. req=1 returns to ASSERT
//             with ctr=0. When ctr==GAP_LEN-1: go to IDLE.
//     IDLE:   both outputs high, busy_o=0. req=1 goes to ASSERT with ctr=0.
//   - Timing: with req=0 throughout, ASSERT entered at edge k releases periph at edge
//     k+PULSE_LEN and core at edge k+PULSE_LEN+GAP_LEN.
//   - A req sampled at edge k in IDLE or GAP drives both outputs low from edge k. There
//     is no extra latency; outputs are decoded into flops from next state.
//   - reason_o updates on every edge where req=1, in any state. Priority on simultaneous
//     requests: wdog > button > software. It holds otherwise and persists through IDLE.
//   - Counter width: $clog2(max(PULSE_LEN,GAP_LEN)+1). It never wraps, because the state
//     changes at the terminal count.
//   - No combinational path from inputs to outputs. No glitches on the reset outputs.
//
// TESTING (PULSE_LEN=8, GAP_LEN=4)
//   1. rst_n low 3 cycles, then high, no reqs -> outputs 0 during reset; periph=1 at
//      edge 8, core=1 at edge 12 after release; reason=00; busy falls with core.
//   2. IDLE, sw_req_i pulse at edge k -> outputs 0 from edge k; periph=1 at k+8;
//      core=1 at k+12; reason=10.
//   3. btn_req_i held 20 cycles -> outputs stay 0 the whole time; periph releases
//      8 cycles after btn falls; reason=01.
//   4. wdog_req_i pulse during GAP (periph=1, core=0) -> periph returns to 0 at once;
//      full 8+4 sequence restarts; reason=11.
//   5. sw_req_i and wdog_req_i in the same cycle -> reason=11. btn and sw together
//      -> reason=01.
//   6. rst_n asserted mid-ASSERT and mid-GAP -> outputs 0 and reason=00 immediately,
//      without a clock edge; full sequence replays after release.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer
//
// Purpose:
//   Turns clean, synchronous reset requests into stretched, ordered
//   active-low reset outputs. The requests come from the conditioned
//   button, a software register and the watchdog. The peripheral reset
//   is released first and the core reset follows after a gap. The block
//   also records the cause of the most recent reset.
//
// Parameters:
//   PULSE_LEN  cycles both resets stay asserted after the last request (>=1)
//   GAP_LEN    cycles between peripheral release and core release (>=1)
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low power-on reset
//   btn_req_i      conditioned button level; holding it extends the reset
//   sw_req_i       software reset request, single-cycle pulse
//   wdog_req_i     watchdog reset request, single-cycle pulse
//   periph_rst_n_o peripheral reset, active low, registered
//   core_rst_n_o   core reset, active low, registered
//   busy_o         high while a reset sequence is in progress
//   reason_o       last cause: 00 POR, 01 button, 10 software, 11 watchdog

module reset_sequencer #(
  parameter int PULSE_LEN = 32,
  parameter int GAP_LEN   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_req_i,
  input  logic       sw_req_i,
  input  logic       wdog_req_i,
  output logic       periph_rst_n_o,
  output logic       core_rst_n_o,
  output logic       busy_o,
  output logic [1:0] reason_o
);

  localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_LEN - 1);

  localparam logic [1:0] REASON_POR  = 2'b00;
  localparam logic [1:0] REASON_BTN  = 2'b01;
  localparam logic [1:0] REASON_SW   = 2'b10;
  localparam logic [1:0] REASON_WDOG = 2'b11;

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_GAP    = 2'd1,
    ST_IDLE   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] ctr;
  logic [CW-1:0] ctr_nxt;
  logic          req;

  assign req = btn_req_i | sw_req_i | wdog_req_i;

  // Next-state and counter decode. Any request sends the sequencer back to
  // ASSERT with a cleared counter, so the pulse is always measured from the
  // last request. Each state leaves on its terminal count, which is why the
  // counter never needs to wrap.
  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    unique case (state)
      ST_ASSERT: begin
        if (req) begin
          ctr_nxt = '0;
        end else if (ctr == PULSE_LAST) begin
          state_nxt = ST_GAP;
          ctr_nxt   = '0;
        end else begin
          ctr_nxt = ctr + CW'(1);
        end
      end
      ST_GAP: begin
        if (req) begin
          state_nxt = ST_ASSERT;
          ctr_nxt   = '0;
        end else if (ctr == GAP_LAST) begin
          state_nxt = ST_IDLE;
          ctr_nxt   = '0;
        end else begin
          ctr_nxt = ctr + CW'(1);
        end
      end
      ST_IDLE: begin
        if (req) begin
          state_nxt = ST_ASSERT;
          ctr_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_ASSERT;
        ctr_nxt   = '0;
      end
    endcase
  end

  // State register. The outputs are decoded from the next state into flops,
  // so a request pulls both resets low on the same edge that samples it,
  // and nothing combinational reaches the reset pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_ASSERT;
      ctr            <= '0;
      periph_rst_n_o <= 1'b0;
      core_rst_n_o   <= 1'b0;
      busy_o         <= 1'b1;
      reason_o       <= REASON_POR;
    end else begin
      state          <= state_nxt;
      ctr            <= ctr_nxt;
      periph_rst_n_o <= (state_nxt != ST_ASSERT);
      core_rst_n_o   <= (state_nxt == ST_IDLE);
      busy_o         <= (state_nxt != ST_IDLE);
      // The watchdog has the highest priority, then the button, then software.
      if (wdog_req_i) begin
        reason_o <= REASON_WDOG;
      end else if (btn_req_i) begin
        reason_o <= REASON_BTN;
      end else if (sw_req_i) begin
        reason_o <= REASON_SW;
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//
// Purpose:
//   Self-checking bench for reset_sequencer with PULSE_LEN=8 and GAP_LEN=4.
//   A table of per-cycle vectors holds the request inputs and the expected
//   {periph, core, busy, reason} after each clock edge. Hand-written
//   sequences cover the power-on reset and asynchronous resets in the
//   middle of a sequence.

module tb_reset_sequencer;

  localparam int PULSE_LEN = 8;
  localparam int GAP_LEN   = 4;

  logic       clk;
  logic       rst_n;
  logic       btn_req_i;
  logic       sw_req_i;
  logic       wdog_req_i;
  logic       periph_rst_n_o;
  logic       core_rst_n_o;
  logic       busy_o;
  logic [1:0] reason_o;

  int errors;
  int checks;

  typedef struct {
    logic       btn;
    logic       sw;
    logic       wdog;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  reset_sequencer #(
    .PULSE_LEN(PULSE_LEN),
    .GAP_LEN  (GAP_LEN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_req_i     (btn_req_i),
    .sw_req_i      (sw_req_i),
    .wdog_req_i    (wdog_req_i),
    .periph_rst_n_o(periph_rst_n_o),
    .core_rst_n_o  (core_rst_n_o),
    .busy_o        (busy_o),
    .reason_o      (reason_o)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Appends n identical cycles to the vector table.
  task automatic addRun(input int n, input logic btn, input logic sw, input logic wdog,
                        input logic p, input logic c, input logic b, input logic [1:0] r);
    vec_t v;
    v.btn  = btn;
    v.sw   = sw;
    v.wdog = wdog;
    v.exp  = {p, c, b, r};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Compares the DUT outputs against {periph, core, busy, reason}.
  task automatic checkOutput(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {periph_rst_n_o, core_rst_n_o, busy_o, reason_o};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got periph=%b core=%b busy=%b reason=%b, expected periph=%b core=%b busy=%b reason=%b",
               name, act[4], act[3], act[2], act[1:0], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Drives one cycle of requests, clocks it in and checks just after the edge.
  task automatic applyStimulus(input int idx);
    btn_req_i  = vecs[idx].btn;
    sw_req_i   = vecs[idx].sw;
    wdog_req_i = vecs[idx].wdog;
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d", idx), vecs[idx].exp);
  endtask

  // Releases rst_n and checks the full power-on sequence edge by edge.
  task automatic checkReplay(input string tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= PULSE_LEN + GAP_LEN + 1; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s_edge%0d", tag, i),
                  {(i >= PULSE_LEN), (i >= PULSE_LEN + GAP_LEN),
                   (i < PULSE_LEN + GAP_LEN), 2'b00});
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst_n      = 1'b0;
    btn_req_i  = 1'b0;
    sw_req_i   = 1'b0;
    wdog_req_i = 1'b0;

    // Table, starting in IDLE after the power-on sequence.
    // Software pulse: low at k, periph at k+8, core at k+12.
    addRun(1, 0, 1, 0, 0, 0, 1, 2'b10);
    addRun(7, 0, 0, 0, 0, 0, 1, 2'b10);
    addRun(4, 0, 0, 0, 1, 0, 1, 2'b10);
    addRun(2, 0, 0, 0, 1, 1, 0, 2'b10);
    // Button held 20 cycles, then periph releases 8 edges after it falls.
    addRun(20, 1, 0, 0, 0, 0, 1, 2'b01);
    addRun(7, 0, 0, 0, 0, 0, 1, 2'b01);
    addRun(2, 0, 0, 0, 1, 0, 1, 2'b01);
    // Watchdog in GAP pulls periph low at once and restarts 8+4.
    addRun(1, 0, 0, 1, 0, 0, 1, 2'b11);
    addRun(7, 0, 0, 0, 0, 0, 1, 2'b11);
    addRun(4, 0, 0, 0, 1, 0, 1, 2'b11);
    addRun(1, 0, 0, 0, 1, 1, 0, 2'b11);
    // Simultaneous requests and priority.
    addRun(1, 1, 1, 0, 0, 0, 1, 2'b01);
    addRun(1, 0, 1, 1, 0, 0, 1, 2'b11);
    addRun(1, 1, 1, 0, 0, 0, 1, 2'b01);
    addRun(1, 0, 1, 0, 0, 0, 1, 2'b10);
    addRun(1, 1, 0, 1, 0, 0, 1, 2'b11);
    addRun(7, 0, 0, 0, 0, 0, 1, 2'b11);
    addRun(4, 0, 0, 0, 1, 0, 1, 2'b11);
    addRun(2, 0, 0, 0, 1, 1, 0, 2'b11);

    // Power-on reset: outputs held low for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("por_hold%0d", i), 5'b00_1_00);
    end
    rst_n = 1'b0;
    #1;
    checkReplay("por");

    foreach (vecs[i]) applyStimulus(i);

    // Asynchronous reset in the middle of ASSERT.
    btn_req_i = 1'b0;
    sw_req_i  = 1'b1;
    @(posedge clk);
    #1;
    sw_req_i = 1'b0;
    checkOutput("midassert_pre", 5'b00_1_10);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midassert_async", 5'b00_1_00);
    checkReplay("midassert");

    // Asynchronous reset in the middle of GAP.
    sw_req_i = 1'b1;
    @(posedge clk);
    #1;
    sw_req_i = 1'b0;
    repeat (PULSE_LEN + 1) @(posedge clk);
    #1;
    checkOutput("midgap_pre", 5'b10_1_10);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midgap_async", 5'b00_1_00);
    checkReplay("midgap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
